minga_sketch_readout: RTL

Read-side engine for the MINGA sketch. On a start pulse it scans every bucket of the counter RAM and the ID RAM in address order. It then streams one (address, ID, count) record per bucket to the host/export logic over a valid/ready interface. It sits beside the insert pipeline and uses the spare read ports of the two 64K x 32 RAMs. Software must stop insertion while a scan runs.

---
 rtl/minga_pkg.sv | 20 ++
 rtl/minga_sync_fifo.sv | 45 ++++
 rtl/minga_sketch_readout.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/minga_pkg.sv
// Shared types for the MINGA sketch readout engine: default widths, FSM states and the record carried through the skid FIFO.
package minga_pkg;

  localparam int MINGA_ADDR_W = 16;
  localparam int MINGA_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN
  } minga_state_e;

  // Sized for the widest supported configuration; narrower builds zero-extend into it.
  typedef struct packed {
    logic [MINGA_ADDR_W-1:0] addr;
    logic [MINGA_DATA_W-1:0] id;
    logic [MINGA_DATA_W-1:0] count;
  } minga_rec_t;

endpackage

// File: rtl/minga_sync_fifo.sv
// Small synchronous FIFO with occupancy count; the head entry is read straight from the storage registers.
module minga_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/minga_sketch_readout.sv
// Scans every bucket of the counter/ID RAMs and streams (addr, id, count) records over valid/ready.
// Optional MINGA_CLEAR_ON_READ_EN zeroes each counter as its data returns. ADDR_W <= 16, DATA_W <= 32.
module minga_sketch_readout
  import minga_pkg::*;
#(
  parameter int ADDR_W     = MINGA_ADDR_W,
  parameter int DATA_W     = MINGA_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              skip_zero,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] counter_rd_data,
  input  logic [DATA_W-1:0] id_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_id,
  output logic [DATA_W-1:0] out_count,
  output logic [ADDR_W:0]   rec_cnt
`ifdef MINGA_CLEAR_ON_READ_EN
  ,
  output logic              clr_wr_en,
  output logic [ADDR_W-1:0] clr_wr_addr,
  output logic [DATA_W-1:0] clr_wr_data
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

  minga_state_e      state;
  logic [ADDR_W:0]   ptr;
  logic              skip_lat;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  inflight_nxt;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  fifo_nxt;
  logic [RD_LAT-1:0] ret_pipe;
  logic [ADDR_W-1:0] addr_pipe [RD_LAT];
  logic              ret_valid;
  logic [ADDR_W-1:0] ret_addr;
  logic              push;
  logic              pop;
  logic              credit_ok;
  logic              fifo_full;
  logic              fifo_empty;
  minga_rec_t        rec_in;
  minga_rec_t        rec_head;

  // A read is only issued when a FIFO slot is guaranteed for its data, so backpressure can never overflow the FIFO.
  assign credit_ok    = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH);
  assign rd_en        = (state == ST_SCAN) && credit_ok;
  assign rd_addr      = ptr[ADDR_W-1:0];
  assign ret_valid    = ret_pipe[RD_LAT-1];
  assign ret_addr     = addr_pipe[RD_LAT-1];
  assign push         = ret_valid && !(skip_lat && (counter_rd_data == '0));
  assign pop          = out_valid && out_ready;
  assign inflight_nxt = inflight + CNT_W'(rd_en) - CNT_W'(ret_valid);
  assign fifo_nxt     = fifo_count + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    rec_in       = '0;
    rec_in.addr  = MINGA_ADDR_W'(ret_addr);
    rec_in.id    = MINGA_DATA_W'(id_rd_data);
    rec_in.count = MINGA_DATA_W'(counter_rd_data);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_pipe <= '0;
      inflight <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_pipe[i] <= '0;
    end else begin
      ret_pipe[0]  <= rd_en;
      addr_pipe[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        ret_pipe[i]  <= ret_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
      inflight <= inflight_nxt;
    end
  end

  // done fires in the cycle right after the final handshake, looking ahead at next-cycle occupancy.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      skip_lat <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rec_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (pop) rec_cnt <= rec_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            skip_lat <= skip_zero;
            rec_cnt  <= '0;
            ptr      <= '0;
            busy     <= 1'b1;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (rd_en) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST_ADDR) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((inflight_nxt == '0) && (fifo_nxt == '0)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  minga_sync_fifo #(
    .WIDTH($bits(minga_rec_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .push   (push),
    .wdata  (rec_in),
    .pop    (pop),
    .rdata  (rec_head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_addr  = out_valid ? rec_head.addr[ADDR_W-1:0]  : '0;
  assign out_id    = out_valid ? rec_head.id[DATA_W-1:0]    : '0;
  assign out_count = out_valid ? rec_head.count[DATA_W-1:0] : '0;

  no_fifo_overflow: assert property (@(posedge sys_clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));

`ifdef MINGA_CLEAR_ON_READ_EN
  // Every returned read clears its counter, even when the record itself is skipped.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_wr_en   <= 1'b0;
      clr_wr_addr <= '0;
    end else begin
      clr_wr_en   <= ret_valid;
      clr_wr_addr <= ret_addr;
    end
  end

  assign clr_wr_data = '0;
`endif

endmodule
